// File: rtl/alu_exec_ctrl.sv
// RV32 OP/OP-IMM execute sequencer: single-cycle ALU ops, iterative shift-add MUL,
// valid/ready issue and writeback handshakes with flush.
module alu_exec_ctrl #(
   parameter int MUL_BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  opcode,
   input  logic [6:0]  funct7,
   input  logic [2:0]  funct3,
   input  logic [11:0] imm,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic [4:0]  rd_addr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rd_val,
   output logic [4:0]  out_rd_addr,
   output logic        out_illegal,
   output logic        busy
);

   localparam int MUL_CYCLES = 32 / MUL_BITS_PER_CYCLE;
   localparam int CNT_W      = $clog2(MUL_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] F7_BASE  = 7'b0000000;
   localparam logic [6:0] F7_ALT   = 7'b0100000;
   localparam logic [6:0] F7_MULDV = 7'b0000001;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_RESP} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  mul_cnt;
   logic [31:0]       mul_acc, mul_mcand, mul_mplier, mul_sum;
   logic              accept, is_mul, alu_ill;
   logic [31:0]       alu_res;

   // Returns {illegal, result}; undefined encodings yield a zero result.
   function automatic logic [32:0] alu_eval(input logic [6:0] op, input logic [6:0] f7,
                                            input logic [2:0] f3, input logic [11:0] im,
                                            input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] a_s, b_s, i_s;
      logic [31:0]        i_u, r;
      logic               ill;
      a_s = a;
      b_s = b;
      i_s = {{20{im[11]}}, im};
      i_u = i_s;
      r   = '0;
      ill = 1'b0;
      case (op)
         OP_R: begin
            case ({f7, f3})
               {F7_BASE, 3'b000}: r = a + b;
               {F7_ALT,  3'b000}: r = a - b;
               {F7_BASE, 3'b001}: r = a << b[4:0];
               {F7_BASE, 3'b010}: r = {31'b0, a_s < b_s};
               {F7_BASE, 3'b011}: r = {31'b0, a < b};
               {F7_BASE, 3'b100}: r = a ^ b;
               {F7_BASE, 3'b101}: r = a >> b[4:0];
               {F7_ALT,  3'b101}: r = a_s >>> b[4:0];
               {F7_BASE, 3'b110}: r = a | b;
               {F7_BASE, 3'b111}: r = a & b;
               default:           ill = 1'b1;
            endcase
         end
         OP_I: begin
            case (f3)
               3'b000: r = a + i_u;
               3'b010: r = {31'b0, a_s < i_s};
               3'b011: r = {31'b0, a < i_u};
               3'b100: r = a ^ i_u;
               3'b110: r = a | i_u;
               3'b111: r = a & i_u;
               3'b001: begin
                  if (im[11:5] == F7_BASE) r = a << im[4:0];
                  else                     ill = 1'b1;
               end
               default: begin
                  if (im[11:5] == F7_BASE)     r = a >> im[4:0];
                  else if (im[11:5] == F7_ALT) r = a_s >>> im[4:0];
                  else                         ill = 1'b1;
               end
            endcase
         end
         default: ill = 1'b1;
      endcase
      if (ill) r = '0;
      return {ill, r};
   endfunction

   function automatic logic [31:0] mul_step(input logic [31:0] acc, input logic [31:0] mc,
                                            input logic [MUL_BITS_PER_CYCLE-1:0] bits);
      logic [31:0] s;
      s = acc;
      for (int i = 0; i < MUL_BITS_PER_CYCLE; i++)
         if (bits[i]) s = s + (mc << i);
      return s;
   endfunction

   assign is_mul    = (opcode == OP_R) && (funct3 == 3'b000) && (funct7 == F7_MULDV);
   assign {alu_ill, alu_res} = alu_eval(opcode, funct7, funct3, imm, rs1_val, rs2_val);
   assign mul_sum   = mul_step(mul_acc, mul_mcand, mul_mplier[MUL_BITS_PER_CYCLE-1:0]);
   assign in_ready  = rst_n && !flush &&
                      ((state == S_IDLE) || ((state == S_RESP) && out_ready));
   assign accept    = in_valid && in_ready;
   assign busy      = (state == S_MUL);
   assign out_valid = (state == S_RESP);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = is_mul ? S_MUL : S_RESP;
         S_MUL:   if (mul_cnt == CNT_LAST) state_nxt = S_RESP;
         S_RESP: begin
            if (accept)         state_nxt = is_mul ? S_MUL : S_RESP;
            else if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mul_cnt     <= '0;
         mul_acc     <= '0;
         mul_mcand   <= '0;
         mul_mplier  <= '0;
         out_rd_val  <= '0;
         out_rd_addr <= '0;
         out_illegal <= 1'b0;
      end else if (flush) begin
         mul_cnt <= '0;
      end else if (accept) begin
         out_rd_addr <= rd_addr;
         if (is_mul) begin
            mul_mcand  <= rs1_val;
            mul_mplier <= rs2_val;
            mul_acc    <= '0;
            mul_cnt    <= '0;
         end else begin
            out_rd_val  <= alu_res;
            out_illegal <= alu_ill;
         end
      end else if (state == S_MUL) begin
         // Retire MUL_BITS_PER_CYCLE multiplier bits per cycle, LSB first.
         mul_acc    <= mul_sum;
         mul_mcand  <= mul_mcand << MUL_BITS_PER_CYCLE;
         mul_mplier <= mul_mplier >> MUL_BITS_PER_CYCLE;
         mul_cnt    <= mul_cnt + 1'b1;
         if (mul_cnt == CNT_LAST) begin
            out_rd_val  <= mul_sum;
            out_illegal <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed plus randomized bench for alu_exec_ctrl against an arithmetic reference model.
module tb_alu_exec_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal, busy;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [11:0] imm;
   logic [31:0] rs1_val, rs2_val, out_rd_val;
   logic [4:0]  rd_addr, out_rd_addr;

   int n_vec = 0;
   int n_err = 0;

   alu_exec_ctrl #(.MUL_BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct7(funct7), .funct3(funct3), .imm(imm),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd_val(out_rd_val),
      .out_rd_addr(out_rd_addr), .out_illegal(out_illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sra_ref(input logic [31:0] a, input int sh);
      logic [63:0] t;
      t = {{32{a[31]}}, a} >> sh;
      return t[31:0];
   endfunction

   // Reference: RV32 semantics written directly from the instruction definitions.
   task automatic ref_alu(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [11:0] im, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic ill, output bit mul);
      logic [31:0] ix;
      logic [63:0] prod;
      int          sh;
      ix  = {{20{im[11]}}, im};
      r   = 0;
      ill = 0;
      mul = 0;
      if (op == 7'h33) begin
         sh = int'(b[4:0]);
         if (f7 == 7'h01 && f3 == 3'd0) begin
            mul  = 1;
            prod = 64'(a) * 64'(b);
            r    = prod[31:0];
         end else if (f7 == 7'h00) begin
            case (f3)
               3'd0: r = a + b;
               3'd1: r = a << sh;
               3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               3'd3: r = (a < b) ? 32'd1 : 32'd0;
               3'd4: r = a ^ b;
               3'd5: r = a >> sh;
               3'd6: r = a | b;
               default: r = a & b;
            endcase
         end else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
         else if (f7 == 7'h20 && f3 == 3'd5)     r = sra_ref(a, sh);
         else ill = 1;
      end else if (op == 7'h13) begin
         sh = int'(im[4:0]);
         case (f3)
            3'd0: r = a + ix;
            3'd2: r = ($signed(a) < $signed(ix)) ? 32'd1 : 32'd0;
            3'd3: r = (a < ix) ? 32'd1 : 32'd0;
            3'd4: r = a ^ ix;
            3'd6: r = a | ix;
            3'd7: r = a & ix;
            3'd1: if (im[11:5] == 7'h00) r = a << sh; else ill = 1;
            default: begin
               if (im[11:5] == 7'h00)      r = a >> sh;
               else if (im[11:5] == 7'h20) r = sra_ref(a, sh);
               else                        ill = 1;
            end
         endcase
      end else ill = 1;
      if (ill) r = 0;
   endtask

   task automatic drive(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [11:0] im, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      opcode = op; funct7 = f7; funct3 = f3; imm = im;
      rs1_val = a; rs2_val = b; rd_addr = rd;
   endtask

   task automatic scramble();
      drive(7'($urandom), 7'($urandom), 3'($urandom), 12'($urandom), $urandom, $urandom,
            5'($urandom));
   endtask

   // Issue one op from IDLE, wait for its result, check it, then retire it.
   task automatic run_op(input string tag, input logic [6:0] op, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [11:0] im, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
      logic [31:0] exp_r;
      logic        exp_ill;
      bit          mul;
      int          lat;
      ref_alu(op, f7, f3, im, a, b, exp_r, exp_ill, mul);
      drive(op, f7, f3, im, a, b, rd);
      in_valid  = 1;
      out_ready = 0;
      #1;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 0;
      scramble();
      lat = 1;
      while (!out_valid && lat < 100) begin
         chk({tag, ".busy"}, 32'(busy), 32'd1);
         chk({tag, ".in_ready_mul"}, 32'(in_ready), 32'd0);
         step();
         lat++;
      end
      chk({tag, ".latency"}, 32'(lat), mul ? 32'd33 : 32'd1);
      chk({tag, ".val"}, out_rd_val, exp_r);
      chk({tag, ".addr"}, 32'(out_rd_addr), 32'(rd));
      chk({tag, ".illegal"}, 32'(out_illegal), 32'(exp_ill));
      out_ready = 1;
      step();
      out_ready = 0;
      chk({tag, ".retired"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [6:0]  rop, rf7;
      logic [11:0] rim;
      int          seen;

      rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      chk("rst.out_valid", 32'(out_valid), 0);
      chk("rst.val", out_rd_val, 0);
      chk("rst.addr", 32'(out_rd_addr), 0);
      chk("rst.illegal", 32'(out_illegal), 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.in_ready", 32'(in_ready), 0);
      rst_n = 1;
      step();

      run_op("add_wrap", 7'h33, 7'h00, 3'd0, 12'h000, 32'h7FFFFFFF, 32'd1, 5'd5);
      run_op("srai", 7'h13, 7'h55, 3'd5, 12'h404, 32'h80000010, 32'd0, 5'd6);
      run_op("sltiu", 7'h13, 7'h00, 3'd3, 12'hFFF, 32'd5, 32'd0, 5'd7);
      run_op("slti", 7'h13, 7'h00, 3'd2, 12'hFFF, 32'd5, 32'd0, 5'd8);
      run_op("mul_neg", 7'h33, 7'h01, 3'd0, 12'h000, 32'hFFFFFFFF, 32'd3, 5'd9);
      run_op("slli_bad", 7'h13, 7'h00, 3'd1, 12'h421, 32'd1, 32'd0, 5'd10);

      // Hold off writeback with a new op waiting, then release it for a same-edge accept.
      drive(7'h33, 7'h00, 3'd0, 12'h0, 32'd1, 32'd2, 5'd1);
      in_valid = 1;
      step();
      drive(7'h33, 7'h20, 3'd0, 12'h0, 32'd10, 32'd3, 5'd2);
      for (int i = 0; i < 4; i++) begin
         chk("hold.valid", 32'(out_valid), 1);
         chk("hold.val", out_rd_val, 32'd3);
         chk("hold.addr", 32'(out_rd_addr), 32'd1);
         chk("hold.in_ready", 32'(in_ready), 0);
         step();
      end
      out_ready = 1;
      #1;
      chk("b2b.in_ready", 32'(in_ready), 1);
      step();
      in_valid = 0;
      chk("b2b.valid", 32'(out_valid), 1);
      chk("b2b.val", out_rd_val, 32'd7);
      chk("b2b.addr", 32'(out_rd_addr), 32'd2);
      step();
      out_ready = 0;
      chk("b2b.retired", 32'(out_valid), 0);

      // Flush at MUL cycle 10 with a competing request.
      drive(7'h33, 7'h01, 3'd0, 12'h0, 32'd1234, 32'd5678, 5'd3);
      in_valid = 1;
      step();
      in_valid = 0;
      repeat (9) step();
      chk("flush.busy_before", 32'(busy), 1);
      flush = 1;
      in_valid = 1;
      drive(7'h33, 7'h00, 3'd0, 12'h0, 32'd9, 32'd9, 5'd4);
      #1;
      chk("flush.in_ready_forced", 32'(in_ready), 0);
      step();
      flush = 0;
      in_valid = 0;
      #1;
      chk("flush.busy", 32'(busy), 0);
      chk("flush.out_valid", 32'(out_valid), 0);
      chk("flush.in_ready", 32'(in_ready), 1);
      seen = 0;
      repeat (40) begin
         step();
         if (out_valid) seen++;
      end
      chk("flush.no_result", 32'(seen), 0);
      run_op("add_after_flush", 7'h33, 7'h00, 3'd0, 12'h0, 32'd2, 32'd3, 5'd11);

      // Flush drops a pending result even with out_ready high.
      drive(7'h33, 7'h00, 3'd4, 12'h0, 32'hF0, 32'h0F, 5'd12);
      in_valid = 1;
      step();
      chk("rflush.pending", 32'(out_valid), 1);
      flush = 1;
      out_ready = 1;
      step();
      flush = 0;
      in_valid = 0;
      out_ready = 0;
      chk("rflush.dropped", 32'(out_valid), 0);
      step();
      chk("rflush.stays_idle", 32'(out_valid), 0);

      // Illegal funct7, then reset while its result sits in RESP.
      drive(7'h33, 7'h21, 3'd0, 12'h0, 32'd77, 32'd88, 5'd13);
      in_valid = 1;
      step();
      in_valid = 0;
      chk("ill.valid", 32'(out_valid), 1);
      chk("ill.flag", 32'(out_illegal), 1);
      chk("ill.val", out_rd_val, 0);
      chk("ill.addr", 32'(out_rd_addr), 32'd13);
      rst_n = 0;
      step();
      chk("rresp.valid", 32'(out_valid), 0);
      chk("rresp.illegal", 32'(out_illegal), 0);
      chk("rresp.addr", 32'(out_rd_addr), 0);
      chk("rresp.val", out_rd_val, 0);
      chk("rresp.busy", 32'(busy), 0);
      rst_n = 1;
      step();

      // Randomized ops, legal encodings favoured.
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 7))
            0:       rop = 7'($urandom);
            1, 2, 3: rop = 7'h33;
            default: rop = 7'h13;
         endcase
         case ($urandom_range(0, 5))
            0:       rf7 = 7'h20;
            1:       rf7 = 7'h01;
            2:       rf7 = 7'($urandom);
            default: rf7 = 7'h00;
         endcase
         rim = 12'($urandom);
         if ($urandom_range(0, 2) != 0) rim[11:5] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
         run_op("rand", rop, rf7, 3'($urandom), rim, $urandom, $urandom, 5'($urandom));
      end
      run_op("rand_mul", 7'h33, 7'h01, 3'd0, 12'($urandom), $urandom, $urandom, 5'd31);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
